// File: rtl/input_port_requester_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : input_port_requester_if
// Purpose  : Link-side and switch-side signal bundle for one router input port.
//            slave modport = requester view, master modport = link/switch view.
//            Optional pkt_count under INPUT_PORT_REQUESTER_STATS_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface input_port_requester_if #(
  parameter int FLIT_BITS        = 32,
  parameter int DESTINATION_BITS = 4
);
  logic [FLIT_BITS-1:0]        in_flit;
  logic                        in_valid;
  logic                        in_ready;
  logic                        send;
  logic [DESTINATION_BITS-1:0] dest;
  logic                        isHead;
  logic                        grant;
  logic [FLIT_BITS-1:0]        out_flit;
  logic                        err;
`ifdef INPUT_PORT_REQUESTER_STATS_EN
  logic [15:0]                 pkt_count;
`endif

  modport slave (
    input  in_flit, in_valid, grant,
`ifdef INPUT_PORT_REQUESTER_STATS_EN
    output pkt_count,
`endif
    output in_ready, send, dest, isHead, out_flit, err
  );

  modport master (
    output in_flit, in_valid, grant,
`ifdef INPUT_PORT_REQUESTER_STATS_EN
    input  pkt_count,
`endif
    input  in_ready, send, dest, isHead, out_flit, err
  );
endinterface
`default_nettype wire

// File: rtl/input_port_requester.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : input_port_requester
// Purpose  : Per-input-port flit FIFO and packet request generator feeding the
//            crossbar switch. Tracks head/tail boundaries, presents the front
//            flit with send/dest/isHead and pops on grant. Sticky err flags
//            orphan body/tail flits and packets missing their tail.
// Options  : INPUT_PORT_REQUESTER_STATS_EN adds a 16-bit delivered-packet count.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module input_port_requester #(
  parameter int ID               = 0,
  parameter int DESTINATION_BITS = 4,
  parameter int FLIT_BITS        = 32,
  parameter int DEPTH            = 4,
  parameter int ADDR_BITS        = 2
) (
  input  wire logic                clk,
  input  wire logic                reset,   // asynchronous, active low
  input_port_requester_if.slave    port
);

  localparam logic [ADDR_BITS-1:0] c_PTR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   c_CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   c_CNT_FULL = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  logic [FLIT_BITS-1:0]        r_mem [DEPTH];
  logic [ADDR_BITS-1:0]        r_wr_ptr;
  logic [ADDR_BITS-1:0]        r_rd_ptr;
  logic [ADDR_BITS:0]          r_count;
  state_t                      r_state;
  logic [DESTINATION_BITS-1:0] r_dest_q;
  logic                        r_err;

  logic [FLIT_BITS-1:0]        w_front;
  logic                        w_empty;
  logic                        w_front_head;
  logic                        w_front_tail;
  logic                        w_send;
  logic                        w_is_head;
  logic [DESTINATION_BITS-1:0] w_dest;
  logic                        w_drop;
  logic                        w_missing_tail;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_unused_id;

  // ID is informational only.
  assign w_unused_id = (ID != 0);

  assign w_front      = r_mem[r_rd_ptr];
  assign w_empty      = (r_count == '0);
  // Type bit 0 marks a head, bit 1 marks a tail (11 = single-flit packet).
  assign w_front_head = w_front[FLIT_BITS-2];
  assign w_front_tail = w_front[FLIT_BITS-1];

  assign w_push = port.in_valid & port.in_ready;
  // Orphan drops pop without involving the switch.
  assign w_pop  = (w_send & port.grant) | w_drop;

  // Request decode from current state and the FIFO front.
  always_comb begin
    w_send         = 1'b0;
    w_is_head      = 1'b0;
    w_dest         = r_dest_q;
    w_drop         = 1'b0;
    w_missing_tail = 1'b0;
    if (!w_empty) begin
      if (r_state == ST_IDLE) begin
        if (w_front_head) begin
          w_send    = 1'b1;
          w_is_head = 1'b1;
          w_dest    = w_front[DESTINATION_BITS-1:0];
        end else begin
          w_drop = 1'b1;
        end
      end else begin
        // A new head inside a packet is held back (no request) until the
        // FSM has returned to IDLE, so a grant cannot consume it as body.
        if (w_front_head) begin
          w_missing_tail = 1'b1;
        end else begin
          w_send = 1'b1;
        end
      end
    end
  end

  assign port.in_ready = (r_count != c_CNT_FULL);
  assign port.send     = w_send;
  assign port.isHead   = w_is_head;
  assign port.dest     = w_dest;
  assign port.out_flit = w_front;
  assign port.err      = r_err;

  // FIFO storage; contents need no reset, validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= port.in_flit;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Packet FSM: tracks whether a packet is open, its destination and errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_dest_q <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_drop) begin
            r_err <= 1'b1;
          end else if (w_pop) begin
            r_dest_q <= w_front[DESTINATION_BITS-1:0];
            if (!w_front_tail) r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_missing_tail) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_pop && w_front_tail) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef INPUT_PORT_REQUESTER_STATS_EN
  logic [15:0] r_pkt_count;

  // Count packets delivered to the switch (granted tail or head+tail pops).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pkt_count <= '0;
    end else if (w_send && port.grant && w_front_tail) begin
      r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign port.pkt_count = r_pkt_count;
`endif

endmodule
`default_nettype wire
